// File: rtl/ncl_q4_wavefront_driver_if.sv
// ncl_q4_wavefront_driver_if: value handshake, quad-rail bus, ki/y_obs and status signals of the wavefront driver.
interface ncl_q4_wavefront_driver_if #(parameter int CNT_W = 16);
   logic             data_valid;
   logic [1:0]       data_in;
   logic             in_ready;
   logic [3:0]       rails;
   logic             ki;
   logic             y_obs;
   logic             mismatch;
   logic             err;
   logic [CNT_W-1:0] wave_cnt;
   modport master(input data_valid, data_in, ki, y_obs, output in_ready, rails, mismatch, err, wave_cnt);
   modport slave(output data_valid, data_in, ki, y_obs, input in_ready, rails, mismatch, err, wave_cnt);
endinterface

// File: rtl/ncl_q4_wavefront_driver.sv
// ncl_q4_wavefront_driver: drives 1-of-4 DATA/NULL wavefronts paced by ki and checks the th14 detector output.
module ncl_q4_wavefront_driver #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input logic clk,
   input logic rst,
   ncl_q4_wavefront_driver_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] S_NULL = 2'd0, S_DATA = 2'd1, S_RTN = 2'd2, S_ERR = 2'd3;
   logic [1:0]       state_q, state_d;
   logic [3:0]       rails_q, rails_d;
   logic [TW-1:0]    st_q, st_d, wt_q, wt_d;
   logic             mm_q, mm_d, err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             settle_done, chk, busy, leave, tout;
   assign bus.in_ready = !rst && state_q == S_NULL && settle_done && bus.ki;
   assign bus.rails    = rails_q;
   assign bus.mismatch = mm_q;
   assign bus.err      = err_q;
   assign bus.wave_cnt = cnt_q;
   // st_q saturates at SETTLE; the detector is sampled once, on the edge that completes settling
   always_comb begin
      settle_done = st_q == TW'(SETTLE);
      chk = st_q == TW'(SETTLE - 1);
      busy = state_q == S_DATA || state_q == S_RTN;
      leave = settle_done && (state_q == S_DATA ? !bus.ki : bus.ki);
      tout = wt_q == TW'(TIMEOUT - 1);
      state_d = state_q;
      rails_d = rails_q;
      st_d = settle_done ? st_q : st_q + TW'(1);
      wt_d = busy ? wt_q + TW'(1) : '0;
      mm_d = mm_q | (chk && busy && (bus.y_obs == (state_q == S_RTN)));
      err_d = err_q;
      cnt_d = cnt_q;
      if (state_q == S_NULL && bus.data_valid && bus.in_ready) begin
         state_d = S_DATA;
         rails_d = 4'b0001 << bus.data_in;
         st_d = '0;
      end else if (busy && leave) begin
         state_d = state_q == S_DATA ? S_RTN : S_NULL;
         rails_d = '0;
         st_d = state_q == S_DATA ? '0 : TW'(SETTLE);
         wt_d = '0;
         cnt_d = state_q == S_RTN ? cnt_q + CNT_W'(1) : cnt_q;
      end else if (busy && tout) begin
         state_d = S_ERR;
         rails_d = '0;
         err_d = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_NULL;
         rails_q <= '0;
         st_q <= '0;
         wt_q <= '0;
         mm_q <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rails_q <= rails_d;
         st_q <= st_d;
         wt_q <= wt_d;
         mm_q <= mm_d;
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_ncl_q4_wavefront_driver.sv
// tb_ncl_q4_wavefront_driver: table-driven, directed and random checks against an age-based protocol model.
module tb_ncl_q4_wavefront_driver;
   localparam int SETTLE = 4, TIMEOUT = 64, CNT_W = 16;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   ncl_q4_wavefront_driver_if #(.CNT_W(CNT_W)) bus();
   ncl_q4_wavefront_driver #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [1:0]       din;
      logic             flip;
      logic [3:0]       exp_rails;
      logic             exp_mm;
      logic [CNT_W-1:0] exp_cnt;
   } wave_t;

   int errors = 0, checks = 0, cyc = 0, prev_at = -1;
   int m_ph, m_age;
   logic [3:0] m_rails;
   logic m_mm, m_err;
   logic [CNT_W-1:0] m_cnt;
   logic flip = 1'b0, flip_hi = 1'b0;
   wave_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // model phases: 0 NULL, 1 DATA, 2 RTN, 3 ERR; m_age = edges since the phase was entered
   task automatic tick();
      logic [22:0] exp;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_ph = 0; m_age = 0; m_rails = 0; m_mm = 0; m_err = 0; m_cnt = 0;
      end else if (m_ph == 0) begin
         if (bus.data_valid && bus.ki && m_age >= SETTLE) begin
            m_ph = 1; m_age = 0; m_rails = 4'b0001 << bus.data_in;
         end else m_age++;
      end else if (m_ph == 1 || m_ph == 2) begin
         if (m_age == SETTLE - 1 && bus.y_obs != (m_ph == 1)) m_mm = 1;
         if (m_age >= SETTLE && bus.ki == (m_ph == 2)) begin
            if (m_ph == 2) m_cnt++;
            m_age = m_ph == 2 ? SETTLE : 0;
            m_ph = m_ph == 1 ? 2 : 0;
            m_rails = 0;
         end else if (m_age == TIMEOUT - 1) begin
            m_ph = 3; m_err = 1; m_rails = 0;
         end else m_age++;
      end
      #1;
      exp = {m_rails, !rst && m_ph == 0 && m_age >= SETTLE && bus.ki, m_mm, m_err, m_cnt};
      chk("cycle", {9'd0, bus.rails, bus.in_ready, bus.mismatch, bus.err, bus.wave_cnt}, {9'd0, exp});
      bus.y_obs = ((|bus.rails) & ~flip) | flip_hi;
   endtask

   task automatic accept_val(input logic [1:0] v, output int at);
      int n = 0;
      bus.data_valid = 1'b1;
      bus.data_in = v;
      bus.ki = 1'b1;
      #1;
      while (!bus.in_ready && n < 4 * TIMEOUT) begin
         tick();
         n++;
      end
      chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      at = cyc;
      bus.data_valid = 1'b0;
   endtask

   task automatic do_wave(input wave_t w);
      int at, n = 0;
      accept_val(w.din, at);
      if (prev_at >= 0) chk("spacing_ok", {31'd0, at - prev_at >= 2 * SETTLE + 2}, 32'd1);
      prev_at = at;
      chk("data_rails", {28'd0, bus.rails}, {28'd0, w.exp_rails});
      flip = w.flip;
      while (bus.wave_cnt != w.exp_cnt && n < 4 * TIMEOUT) begin
         bus.ki = ~(|bus.rails);
         tick();
         n++;
      end
      flip = 1'b0;
      bus.ki = 1'b1;
      chk("wave_cnt", {16'd0, bus.wave_cnt}, {16'd0, w.exp_cnt});
      chk("wave_mm", {31'd0, bus.mismatch}, {31'd0, w.exp_mm});
      chk("wave_err", {31'd0, bus.err}, 32'd0);
   endtask

   initial begin
      int at, n;
      tbl[0] = '{2'd2, 1'b0, 4'b0100, 1'b0, 16'd1};
      tbl[1] = '{2'd0, 1'b0, 4'b0001, 1'b0, 16'd2};
      tbl[2] = '{2'd1, 1'b0, 4'b0010, 1'b0, 16'd3};
      tbl[3] = '{2'd2, 1'b0, 4'b0100, 1'b0, 16'd4};
      tbl[4] = '{2'd3, 1'b0, 4'b1000, 1'b0, 16'd5};
      tbl[5] = '{2'd1, 1'b1, 4'b0010, 1'b1, 16'd6};
      tbl[6] = '{2'd3, 1'b0, 4'b1000, 1'b1, 16'd7};
      rst = 1'b1;
      bus.data_valid = 1'b0; bus.data_in = 2'd0; bus.ki = 1'b0; bus.y_obs = 1'b0;
      tick(); tick();
      chk("reset_out", {9'd0, bus.rails, bus.in_ready, bus.mismatch, bus.err, bus.wave_cnt}, 32'd0);
      rst = 1'b0;
      foreach (tbl[i]) do_wave(tbl[i]);

      // ki dropped right after DATA: rails must hold until settling completes
      rst = 1'b1; tick(); rst = 1'b0;
      accept_val(2'd1, at);
      bus.ki = 1'b0;
      n = 0;
      while (bus.rails != 4'b0000 && n < 100) begin
         tick();
         n++;
      end
      chk("early_ki_hold", n, SETTLE + 1);
      bus.ki = 1'b1;
      repeat (2 * SETTLE + 2) tick();
      chk("early_ki_cnt", {16'd0, bus.wave_cnt}, 32'd1);

      // reset in the middle of a DATA wavefront
      accept_val(2'd3, at);
      tick(); tick();
      chk("mid_rails", {28'd0, bus.rails}, 32'b1000);
      rst = 1'b1; tick();
      chk("mid_rst", {12'd0, bus.rails, bus.wave_cnt}, 32'd0);
      rst = 1'b0; bus.data_valid = 1'b1; bus.data_in = 2'd0; bus.ki = 1'b1;
      #1;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         tick();
         n++;
      end
      chk("reset_settle", n, SETTLE);
      bus.data_valid = 1'b0;

      // timeout: ki never drops after DATA
      rst = 1'b1; tick(); rst = 1'b0;
      accept_val(2'd3, at);
      repeat (TIMEOUT + 2) tick();
      chk("tout_err", {31'd0, bus.err}, 32'd1);
      chk("tout_rails", {28'd0, bus.rails}, 32'd0);
      repeat (5) tick();
      chk("tout_ready", {31'd0, bus.in_ready}, 32'd0);
      rst = 1'b1; tick(); rst = 1'b0; tick();
      chk("tout_clear", {9'd0, bus.rails, bus.in_ready, bus.mismatch, bus.err, bus.wave_cnt}, 32'd0);

      // random traffic with occasional detector faults and resets
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(499) == 0;
         bus.data_valid = $urandom_range(1);
         bus.data_in = 2'($urandom_range(3));
         bus.ki = $urandom_range(3) != 0 ? ~(|bus.rails) : bus.ki;
         flip = $urandom_range(15) == 0;
         flip_hi = $urandom_range(15) == 0;
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
